fifo_master: RTL and testbench

FIFO_MASTER -- requirements
Module: fifo_master

---
 rtl/fifo_master_if.sv | 43 ++++
 rtl/fifo_master.sv | 145 ++++++++++++++
 tb/tb_fifo_master.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_master_if.sv
// fifo_master_if -- bundles the upstream write stream, the downstream read
// stream and both sides of the attached FIFO into one interface.
//   master modport : the fifo_master view (drives s_ready, m_*, FIFO controls)
//   slave modport  : the environment view (upstream, downstream and FIFO)
//   WIDTH          : data width of s_data, m_data, data_in and data_out
interface fifo_master_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             fifo_rst_n;
    logic [WIDTH-1:0] data_in;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] data_out;
    logic             wr_ack;
    logic             overflow;
    logic             full;
    logic             empty;
    logic             almostfull;
    logic             almostempty;
    logic             underflow;

    modport master (
        input  s_data, s_valid, m_ready,
        input  data_out, wr_ack, overflow, full, empty,
        input  almostfull, almostempty, underflow,
        output s_ready, m_data, m_valid,
        output fifo_rst_n, data_in, wr_en, rd_en
    );

    modport slave (
        output s_data, s_valid, m_ready,
        output data_out, wr_ack, overflow, full, empty,
        output almostfull, almostempty, underflow,
        input  s_ready, m_data, m_valid,
        input  fifo_rst_n, data_in, wr_en, rd_en
    );
endinterface

// File: rtl/fifo_master.sv
// fifo_master -- drives an external synchronous FIFO (1-cycle read latency):
// forwards an upstream valid/ready stream into the FIFO and drains the FIFO
// into a 2-entry holding buffer that presents a downstream valid/ready stream.
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   bus (master)    : s_* upstream, m_* downstream, FIFO control and status
//   err_overflow    : sticky, set when the FIFO reports overflow
//   err_underflow   : sticky, set when the FIFO reports underflow
//   wr_cnt, rd_cnt  : accepted-write / delivered-word counters (wrap at 16 bits)
// Build option: define FIFO_MASTER_STATS_EN to implement the counters;
// otherwise they are tied to zero and no counter flops exist.
module fifo_master #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    fifo_master_if.master bus,
    output logic         err_overflow,
    output logic         err_underflow,
    output logic [15:0]  wr_cnt,
    output logic [15:0]  rd_cnt
);

    typedef enum logic [1:0] {
        IDLE, // nothing buffered, no read in flight
        FILL, // read in flight or buffer partly filled
        HOLD  // buffer full, reads paused until a pop
    } state_t;

    state_t                state, state_nxt;
    logic [1:0]            occ, occ_nxt;
    logic                  rd_pend;
    logic [FIFO_WIDTH-1:0] slot0, slot1;          // slot0 is the oldest word
    logic [FIFO_WIDTH-1:0] slot0_nxt, slot1_nxt;
    logic                  pop;
    logic                  rd_en;

    // Write side is purely combinational.
    assign bus.fifo_rst_n = ~rst;
    assign bus.s_ready    = !bus.full && !rst;
    assign bus.wr_en      = bus.s_valid && bus.s_ready;
    assign bus.data_in    = bus.s_data;

    assign bus.m_valid = (occ != 2'd0);
    assign bus.m_data  = slot0;
    assign pop         = bus.m_valid && bus.m_ready;

    // Issue a read only if the word will have a slot when it lands one cycle
    // later: occupancy + in-flight - pop must stay below 2.
    assign rd_en     = !bus.empty && !rst &&
                       (({1'b0, occ} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop}));
    assign bus.rd_en = rd_en;

    always_comb begin
        occ_nxt   = occ;
        slot0_nxt = slot0;
        slot1_nxt = slot1;
        state_nxt = state;
        // rd_pend means data_out carries a word this cycle.
        case ({rd_pend, pop})
            2'b01: begin
                slot0_nxt = slot1;
                occ_nxt   = occ - 2'd1;
            end
            2'b10: begin
                if (occ == 2'd0) slot0_nxt = bus.data_out;
                else             slot1_nxt = bus.data_out;
                occ_nxt = occ + 2'd1;
            end
            2'b11: begin
                // Capture and pop together: shift and refill, occupancy unchanged.
                if (occ == 2'd1) begin
                    slot0_nxt = bus.data_out;
                end else begin
                    slot0_nxt = slot1;
                    slot1_nxt = bus.data_out;
                end
            end
            default: ;
        endcase
        if (occ_nxt == 2'd2)                state_nxt = HOLD;
        else if (occ_nxt == 2'd0 && !rd_en) state_nxt = IDLE;
        else                                state_nxt = FILL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Clearing rd_pend drops any word still in flight from before reset.
            occ           <= 2'd0;
            rd_pend       <= 1'b0;
            slot0         <= '0;
            slot1         <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            occ           <= occ_nxt;
            rd_pend       <= rd_en;
            slot0         <= slot0_nxt;
            slot1         <= slot1_nxt;
            err_overflow  <= err_overflow | bus.overflow;
            err_underflow <= err_underflow | bus.underflow;
        end
    end

`ifdef FIFO_MASTER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (bus.wr_ack) wr_cnt <= wr_cnt + 16'd1;
            if (pop)        rd_cnt <= rd_cnt + 16'd1;
        end
    end
`else
    assign wr_cnt = '0;
    assign rd_cnt = '0;
`endif

    // Consistency checks on the read path and on the attached FIFO.
    a_no_wr_full: assert property (@(posedge clk) !(bus.wr_en && bus.full));
    a_no_rd_empty: assert property (@(posedge clk) !(bus.rd_en && bus.empty));
    a_occ_range: assert property (@(posedge clk) occ <= 2'd2);
    a_idle_state: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE) |-> (occ == 2'd0 && !rd_pend));
    a_hold_state: assert property (@(posedge clk) disable iff (rst)
        (state == HOLD) |-> (occ == 2'd2 && !rd_pend));
    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.m_valid && !bus.m_ready) |=> (bus.m_valid && $stable(bus.m_data)));
    a_ack_follows_wr: assert property (@(posedge clk) disable iff (rst)
        bus.wr_ack |-> $past(bus.wr_en));
    a_full_flags: assert property (@(posedge clk) disable iff (rst)
        (FIFO_DEPTH > 2 && bus.full) |-> !bus.almostempty);
    a_empty_flags: assert property (@(posedge clk) disable iff (rst)
        (FIFO_DEPTH > 1 && bus.empty) |-> !bus.almostfull);

endmodule

// File: tb/tb_fifo_master.sv
// tb_fifo_master -- directed bench for fifo_master with a behavioural
// 8-deep FIFO (1-cycle read latency) attached through fifo_master_if.
module tb_fifo_master;
    localparam int unsigned W = 16;
    localparam int unsigned D = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        err_overflow, err_underflow;
    logic [15:0] wr_cnt, rd_cnt;
    logic        force_ovf, force_unf;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    fifo_master_if #(.WIDTH(W)) bus ();

    fifo_master #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .wr_cnt        (wr_cnt),
        .rd_cnt        (rd_cnt)
    );

    // Behavioural FIFO; data register deliberately not reset so stale words
    // remain visible on data_out.
    logic [W-1:0] mem[$];
    int unsigned  count = 0;
    logic [W-1:0] dout = '0;
    logic         ack, ovf, unf;

    assign bus.full        = (count == D);
    assign bus.empty       = (count == 0);
    assign bus.almostfull  = (count >= D - 1);
    assign bus.almostempty = (count <= 1);
    assign bus.data_out    = dout;
    assign bus.wr_ack      = ack;
    assign bus.overflow    = ovf | force_ovf;
    assign bus.underflow   = unf | force_unf;

    always @(posedge clk) begin
        if (!bus.fifo_rst_n) begin
            mem.delete();
            count <= 0;
            ack   <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            ack <= bus.wr_en && !bus.full;
            ovf <= bus.wr_en && bus.full;
            unf <= bus.rd_en && bus.empty;
            if (bus.rd_en && !bus.empty) dout <= mem.pop_front();
            if (bus.wr_en && !bus.full)  mem.push_back(bus.data_in);
            count <= count + ((bus.wr_en && !bus.full) ? 1 : 0)
                           - ((bus.rd_en && !bus.empty) ? 1 : 0);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] exp_q[$];
        logic [W-1:0] next_word, prev_data, want;
        logic         prev_hold;
        int unsigned  sent, got, cyc, nwr;
        logic [15:0]  exp_cnt;

        rst         = 1'b1;
        force_ovf   = 1'b0;
        force_unf   = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h5555;
        bus.m_ready = 1'b1;
        repeat (3) step();

        // Reset state, with upstream and downstream both active.
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_wr_en", bus.wr_en, 0);
        check("rst_rd_en", bus.rd_en, 0);
        check("rst_fifo_rst_n", bus.fifo_rst_n, 0);
        check("rst_errs", {err_overflow, err_underflow}, 0);
        check("rst_cnts", {wr_cnt, rd_cnt}, 0);

        // Fill: 2 words drain into the buffer, 8 fill the FIFO.
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        step();
        for (int i = 1; i <= 10; i++) begin
            bus.s_data  = W'(i);
            bus.s_valid = 1'b1;
            #1;
            check("fill_wr_en", bus.wr_en, 1);
            step();
        end
        bus.s_data = 16'h000B;
        #1;
        check("full_s_ready", bus.s_ready, 0);
        check("full_wr_en", bus.wr_en, 0);
        check("full_m_valid", bus.m_valid, 1);
        check("full_m_data", bus.m_data, 16'h0001);
        check("full_rd_en", bus.rd_en, 0);
        bus.s_valid = 1'b0;

        // Drain at one word per cycle.
        bus.m_ready = 1'b1;
        #1;
        for (int i = 1; i <= 10; i++) begin
            check("drain_m_valid", bus.m_valid, 1);
            check("drain_m_data", bus.m_data, W'(i));
            check("drain_rd_guard", bus.rd_en & bus.empty, 0);
            step();
        end
        check("drain_end_m_valid", bus.m_valid, 0);
        check("drain_end_rd_en", bus.rd_en, 0);

        // Random handshakes, scoreboard ordering and stall stability.
        sent = 0; got = 0; cyc = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        next_word = W'($urandom);
        while (got < 1000 && cyc < 20000) begin
            bus.s_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            bus.s_data  = next_word;
            bus.m_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (prev_hold) check("stall_data", bus.m_data, prev_data);
            if (bus.wr_en) begin
                exp_q.push_back(bus.s_data);
                sent++;
                next_word = W'($urandom);
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("order_extra", 1, 0);
                end else begin
                    want = exp_q.pop_front();
                    check("order", bus.m_data, want);
                end
                got++;
            end
            prev_hold = bus.m_valid && !bus.m_ready;
            prev_data = bus.m_data;
            step();
            cyc++;
        end
        check("rand_words", got, 1000);
        check("rand_errs", {err_overflow, err_underflow}, 0);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;

        // Sticky error flags.
        force_ovf = 1'b1;
        step();
        force_ovf = 1'b0;
        check("ovf_set", err_overflow, 1);
        repeat (3) step();
        check("ovf_held", err_overflow, 1);
        check("ovf_no_unf", err_underflow, 0);
        force_unf = 1'b1;
        step();
        force_unf = 1'b0;
        repeat (2) step();
        check("unf_held", err_underflow, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("err_cleared", {err_overflow, err_underflow}, 0);

        // Reset while a read is in flight.
        step();
        bus.s_data  = 16'hBEEF;
        bus.s_valid = 1'b1;
        #1;
        check("pend_wr_en", bus.wr_en, 1);
        step();
        bus.s_valid = 1'b0;
        #1;
        check("pend_rd_en", bus.rd_en, 1);
        step();
        rst         = 1'b1;
        bus.m_ready = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("pend_m_valid0", bus.m_valid, 0);
        step();
        check("pend_m_valid1", bus.m_valid, 0);
        check("pend_m_data", bus.m_data, 0);
        step();
        check("pend_m_valid2", bus.m_valid, 0);

        // Counter wrap over 65537 writes.
        rst = 1'b1;
        step();
        rst         = 1'b0;
        bus.s_data  = 16'h0000;
        bus.s_valid = 1'b1;
        bus.m_ready = 1'b1;
        nwr = 0; cyc = 0;
        while (nwr < 65537 && cyc < 70000) begin
            @(negedge clk);
            if (bus.wr_en) nwr++;
            cyc++;
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        repeat (8) step();
        check("wrap_writes", nwr, 65537);
`ifdef FIFO_MASTER_STATS_EN
        exp_cnt = 16'h0001;
`else
        exp_cnt = 16'h0000;
`endif
        check("wrap_wr_cnt", wr_cnt, exp_cnt);
        check("wrap_rd_cnt", rd_cnt, exp_cnt);
        check("wrap_m_valid", bus.m_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
